// File: rtl/task_4_shift_pkg.sv
// Shared definitions for the task_4_shift_ext shift register.
// Holds the auto-repeat state encoding, parameter defaults and a counter-width helper.
package task_4_shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_t;

    localparam int WIDTH_DEFAULT      = 8;
    localparam int REPEAT_DLY_DEFAULT = 16;
    localparam int REPEAT_PER_DEFAULT = 4;

    // Bits needed to count up to the longer of the two repeat intervals.
    function automatic int rep_cnt_width(input int dly, input int per);
        return $clog2(((dly > per) ? dly : per) + 1);
    endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer plus falling-edge detector for an active-low push button.
// Everything resets to 0 (pressed) so a key held through reset never yields a press.
// With TASK_4_SHIFT_AUTOREPEAT_EN the synchronized level is also exported.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
`ifdef TASK_4_SHIFT_AUTOREPEAT_EN
    output logic level,
`endif
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

`ifdef TASK_4_SHIFT_AUTOREPEAT_EN
    assign level = sync2;
`endif
    assign fall = prev & ~sync2;

endmodule

// File: rtl/task_4_shift_ext.sv
// Button-driven left/right shift register with rotate mode and a shift counter.
// Defining TASK_4_SHIFT_AUTOREPEAT_EN adds hold-to-repeat on either shift key.
module task_4_shift_ext
    import task_4_shift_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int REPEAT_DLY = REPEAT_DLY_DEFAULT,
    parameter int REPEAT_PER = REPEAT_PER_DEFAULT
) (
    input  logic             clk,
    input  logic             key0_rst,
    input  logic             key1_rshift,
    input  logic             key2_lshift,
    input  logic             sw1_rshift,
    input  logic             sw0_lshift,
    input  logic             sw2_rotate,
    output logic [WIDTH-1:0] ledr,
    output logic [7:0]       shift_cnt
);

    if (WIDTH < 2 || WIDTH > 32 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_check
        $error("task_4_shift_ext: parameter out of range");
    end

    logic r_fall;
    logic l_fall;
    logic single_ev;
    logic do_shift;
    logic shift_right;

    assign single_ev = r_fall ^ l_fall;

`ifdef TASK_4_SHIFT_AUTOREPEAT_EN
    localparam int CW = rep_cnt_width(REPEAT_DLY, REPEAT_PER);

    logic          r_level;
    logic          l_level;
    logic          both_low;
    logic          held_high;
    logic          dly_done;
    logic          per_done;
    logic          rep_fire;
    rep_state_t    state;
    logic          rep_right;
    logic [CW-1:0] rep_cnt;

    key_edge u_key_r (.clk(clk), .rst_n(key0_rst), .key_n(key1_rshift), .level(r_level), .fall(r_fall));
    key_edge u_key_l (.clk(clk), .rst_n(key0_rst), .key_n(key2_lshift), .level(l_level), .fall(l_fall));

    assign both_low  = ~r_level & ~l_level;
    assign held_high = rep_right ? r_level : l_level;
    assign dly_done  = (rep_cnt == CW'(REPEAT_DLY - 1));
    assign per_done  = (rep_cnt == CW'(REPEAT_PER - 1));
    assign rep_fire  = ~both_low & ~held_high &
                       (((state == DELAY) & dly_done) | ((state == REPEAT) & per_done));

    assign do_shift    = single_ev | rep_fire;
    assign shift_right = single_ev ? r_fall : rep_right;

    // A fresh press always restarts the hold timer in the pressed direction.
    always_ff @(posedge clk or negedge key0_rst) begin
        if (!key0_rst) begin
            state     <= IDLE;
            rep_right <= 1'b0;
            rep_cnt   <= '0;
        end else if (single_ev) begin
            state     <= DELAY;
            rep_right <= r_fall;
            rep_cnt   <= '0;
        end else if (state != IDLE && (both_low || held_high)) begin
            state   <= IDLE;
            rep_cnt <= '0;
        end else begin
            case (state)
                DELAY: begin
                    if (dly_done) begin
                        state   <= REPEAT;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + CW'(1);
                    end
                end
                REPEAT: begin
                    if (per_done) rep_cnt <= '0;
                    else          rep_cnt <= rep_cnt + CW'(1);
                end
                default: rep_cnt <= '0;
            endcase
        end
    end
`else
    key_edge u_key_r (.clk(clk), .rst_n(key0_rst), .key_n(key1_rshift), .fall(r_fall));
    key_edge u_key_l (.clk(clk), .rst_n(key0_rst), .key_n(key2_lshift), .fall(l_fall));

    assign do_shift    = single_ev;
    assign shift_right = r_fall;
`endif

    // Rotate mode feeds the bit falling off one end back into the other.
    always_ff @(posedge clk or negedge key0_rst) begin
        if (!key0_rst) begin
            ledr      <= '0;
            shift_cnt <= 8'd0;
        end else if (do_shift) begin
            if (shift_right)
                ledr <= {(sw2_rotate ? ledr[0] : sw1_rshift), ledr[WIDTH-1:1]};
            else
                ledr <= {ledr[WIDTH-2:0], (sw2_rotate ? ledr[WIDTH-1] : sw0_lshift)};
            shift_cnt <= shift_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_task_4_shift_ext.sv
// Self-checking bench for task_4_shift_ext (WIDTH=8, REPEAT_DLY=16, REPEAT_PER=4).
// Long-hold expectations depend on TASK_4_SHIFT_AUTOREPEAT_EN.
module tb_task_4_shift_ext;

    localparam int DLY = 16;
    localparam int PER = 4;

    logic       clk = 1'b0;
    logic       key0_rst = 1'b0;
    logic       key1_rshift = 1'b1;
    logic       key2_lshift = 1'b1;
    logic       sw1_rshift = 1'b0;
    logic       sw0_lshift = 1'b0;
    logic       sw2_rotate = 1'b0;
    logic [7:0] ledr;
    logic [7:0] shift_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_ledr = 8'h00;
    logic [7:0] m_cnt  = 8'h00;
    bit         hist_r[$] = '{1'b0, 1'b0, 1'b0};
    bit         hist_l[$] = '{1'b0, 1'b0, 1'b0};
    bit         m_active = 1'b0;
    bit         m_right = 1'b0;
    int         m_held = 0;

    task_4_shift_ext #(.WIDTH(8), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
        .clk(clk),
        .key0_rst(key0_rst),
        .key1_rshift(key1_rshift),
        .key2_lshift(key2_lshift),
        .sw1_rshift(sw1_rshift),
        .sw0_lshift(sw0_lshift),
        .sw2_rotate(sw2_rotate),
        .ledr(ledr),
        .shift_cnt(shift_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output(input string name, input logic [7:0] exp_ledr, input logic [7:0] exp_cnt);
        check_val({name, "_ledr"}, int'(ledr), int'(exp_ledr));
        check_val({name, "_cnt"}, int'(shift_cnt), int'(exp_cnt));
        check_val({name, "_model_ledr"}, int'(m_ledr), int'(exp_ledr));
        check_val({name, "_model_cnt"}, int'(m_cnt), int'(exp_cnt));
    endtask

    task automatic apply_stimulus(input bit k1, input bit k2, input bit s1, input bit s0, input bit rot);
        key1_rshift = k1;
        key2_lshift = k2;
        sw1_rshift  = s1;
        sw0_lshift  = s0;
        sw2_rotate  = rot;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_shift(input bit right);
        bit inb;
        if (right) begin
            inb    = sw2_rotate ? m_ledr[0] : sw1_rshift;
            m_ledr = (m_ledr >> 1) | (8'(inb) << 7);
        end else begin
            inb    = sw2_rotate ? m_ledr[7] : sw0_lshift;
            m_ledr = (m_ledr << 1) | 8'(inb);
        end
        m_cnt = m_cnt + 8'd1;
    endtask

    // Model: a key's debounced level lags its pin by two edges; reset history counts as pressed.
    always @(posedge clk or negedge key0_rst) begin
        bit low_r, low_l, ev_r, ev_l;
        if (!key0_rst) begin
            m_ledr   = 8'h00;
            m_cnt    = 8'h00;
            hist_r   = '{1'b0, 1'b0, 1'b0};
            hist_l   = '{1'b0, 1'b0, 1'b0};
            m_active = 1'b0;
            m_held   = 0;
        end else begin
            low_r = !hist_r[1];
            low_l = !hist_l[1];
            ev_r  = low_r && hist_r[0];
            ev_l  = low_l && hist_l[0];
            if (ev_r != ev_l) begin
                model_shift(ev_r);
                m_active = 1'b1;
                m_right  = ev_r;
                m_held   = 0;
            end
`ifdef TASK_4_SHIFT_AUTOREPEAT_EN
            else if (m_active) begin
                if ((low_r && low_l) || !(m_right ? low_r : low_l)) begin
                    m_active = 1'b0;
                end else begin
                    m_held++;
                    if (m_held >= DLY && ((m_held - DLY) % PER) == 0)
                        model_shift(m_right);
                end
            end
`endif
            hist_r.push_back(key1_rshift);
            void'(hist_r.pop_front());
            hist_l.push_back(key2_lshift);
            void'(hist_l.pop_front());
        end
    end

    always @(negedge clk) begin
        if (key0_rst) begin
            check_val("ledr_vs_model", int'(ledr), int'(m_ledr));
            check_val("cnt_vs_model", int'(shift_cnt), int'(m_cnt));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_stimulus(1, 1, 0, 0, 0);
        key0_rst = 1'b0;
        wait_neg(3);
        check_output("reset_state", 8'h00, 8'h00);
        key0_rst = 1'b1;
        wait_neg(5);

        // Two right presses filling with 1; shift lands on the third edge.
        apply_stimulus(0, 1, 1, 0, 0);
        wait_neg(2);
        check_output("press1_e2", 8'h00, 8'h00);
        wait_neg(1);
        check_output("press1_e3", 8'h80, 8'h01);
        wait_neg(7);
        apply_stimulus(1, 1, 1, 0, 0);
        wait_neg(5);
        check_output("press1_held", 8'h80, 8'h01);
        apply_stimulus(0, 1, 1, 0, 0);
        wait_neg(2);
        check_output("press2_e2", 8'h80, 8'h01);
        wait_neg(1);
        check_output("press2_e3", 8'hC0, 8'h02);
        wait_neg(7);
        apply_stimulus(1, 1, 1, 0, 0);
        wait_neg(5);

        apply_stimulus(1, 0, 0, 0, 1);
        wait_neg(3);
        check_output("rotate_left", 8'h81, 8'h03);
        wait_neg(4);
        apply_stimulus(1, 1, 0, 0, 1);
        wait_neg(5);

        apply_stimulus(0, 0, 1, 1, 0);
        wait_neg(6);
        check_output("both_keys", 8'h81, 8'h03);
        apply_stimulus(1, 1, 1, 1, 0);
        wait_neg(5);

        apply_stimulus(1, 0, 0, 1, 0);
        wait_neg(3);
        check_output("fill_left", 8'h03, 8'h04);
        apply_stimulus(1, 1, 0, 1, 0);
        wait_neg(5);

        #2 key0_rst = 1'b0;
        #1 check_output("async_reset", 8'h00, 8'h00);
        apply_stimulus(0, 1, 1, 0, 0);
        wait_neg(2);
        key0_rst = 1'b1;
        wait_neg(10);
        check_output("held_through_reset", 8'h00, 8'h00);
        apply_stimulus(1, 1, 1, 0, 0);
        wait_neg(5);
        apply_stimulus(0, 1, 1, 0, 0);
        wait_neg(3);
        check_output("press_after_reset", 8'h80, 8'h01);
        wait_neg(3);
        apply_stimulus(1, 1, 1, 0, 0);
        wait_neg(4);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(0, 1, 1, 0, 0);
            wait_neg(4);
            apply_stimulus(1, 1, 1, 0, 0);
            wait_neg(4);
        end
        check_output("fill_ones", 8'hFF, 8'h08);

        // Long hold with zero fill: one shift per press, plus repeats when enabled.
        apply_stimulus(0, 1, 0, 0, 0);
        wait_neg(39);
        apply_stimulus(1, 1, 0, 0, 0);
        wait_neg(10);
`ifdef TASK_4_SHIFT_AUTOREPEAT_EN
        check_output("long_hold_repeat", 8'h01, 8'h0F);
`else
        check_output("long_hold_single", 8'h7F, 8'h09);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
